// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM/owner types and the MMU address map for the request arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    typedef enum logic {OWN_INSTR, OWN_DATA} owner_e;

    localparam logic [31:0] GPIO_BASE  = 32'h0000_0101;
    localparam logic [31:0] GPIO_LAST  = 32'h0000_0114;
    localparam logic [31:0] TIMER_ADDR = 32'h0000_0115;
    localparam logic [31:0] SRAM_BASE  = 32'h0000_1000;
    localparam logic [31:0] SRAM_LAST  = 32'h0000_1FFF;
    localparam logic [31:0] EXT_BASE   = 32'h0000_2000;

    function automatic owner_e other(input owner_e o);
        return (o == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
    endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-input round-robin picker; a tie goes to the master not served last.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic   i_req0,
    input  logic   i_req1,
    input  owner_e i_last,
    output logic   o_valid,
    output owner_e o_owner
);
    assign o_valid = i_req0 | i_req1;
    assign o_owner = (i_req0 & i_req1) ? other(i_last) : (i_req1 ? OWN_DATA : OWN_INSTR);
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: merges instruction and data masters onto the single MMU request port,
// holding each request stable until answered or timed out, and routing the response back.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req,
    input  logic [31:0]        i_addr,
    output logic               i_gnt,
    output logic               i_rvalid,
    output logic               i_err,
    output logic [MEM_W-1:0]   i_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [31:0]        d_addr,
    input  logic [MEM_W/8-1:0] d_be,
    input  logic [MEM_W-1:0]   d_wdata,
    output logic               d_gnt,
    output logic               d_rvalid,
    output logic               d_err,
    output logic [MEM_W-1:0]   d_rdata,
    output logic               vproc_mem_req_o,
    output logic               vproc_mem_we_o,
    output logic [31:0]        vproc_mem_addr_o,
    output logic [MEM_W/8-1:0] vproc_mem_be_o,
    output logic [MEM_W-1:0]   vproc_mem_wdata_o,
    input  logic               vproc_mem_rvalid_i,
    input  logic               vproc_mem_err_i,
    input  logic [MEM_W-1:0]   vproc_mem_rdata_i
);
    localparam int CW = $clog2(TIMEOUT);

    state_e             r_state, w_state_nxt;
    owner_e             r_owner, r_last, w_pick;
    logic               w_pick_valid, w_timeout, w_done, w_cmp_err;
    logic [CW-1:0]      r_cnt;
    logic               r_gnt, r_rvalid, r_err, r_req, r_we;
    logic [MEM_W-1:0]   r_rdata, r_wdata;
    logic [31:0]        r_addr;
    logic [MEM_W/8-1:0] r_be;

    rr_arb2 u_rr (
        .i_req0  (i_req),
        .i_req1  (d_req),
        .i_last  (r_last),
        .o_valid (w_pick_valid),
        .o_owner (w_pick)
    );

    assign w_timeout = r_cnt == CW'(TIMEOUT - 1);
    assign w_done    = vproc_mem_err_i | vproc_mem_rvalid_i | w_timeout;
    // A silent write is a posted write to timer/GPIO and succeeds; a silent read fails.
    assign w_cmp_err = vproc_mem_err_i | (~vproc_mem_rvalid_i & ~r_we);

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE) w_state_nxt = w_pick_valid ? WAIT : IDLE;
        else if (r_state == WAIT) w_state_nxt = w_done ? RESP : WAIT;
        else w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner  <= OWN_INSTR;
            r_last   <= OWN_DATA;
            r_cnt    <= '0;
            r_gnt    <= 1'b0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_be     <= '0;
            r_wdata  <= '0;
        end else begin
            r_gnt    <= 1'b0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            if (r_state == IDLE) begin
                if (w_pick_valid) begin
                    r_owner <= w_pick;
                    r_gnt   <= 1'b1;
                    r_req   <= 1'b1;
                    r_cnt   <= '0;
                    r_addr  <= (w_pick == OWN_DATA) ? d_addr : i_addr;
                    r_we    <= (w_pick == OWN_DATA) & d_we;
                    r_be    <= (w_pick == OWN_DATA) ? d_be : '1;
                    r_wdata <= (w_pick == OWN_DATA) ? d_wdata : '0;
                end
            end else if (r_state == WAIT) begin
                if (w_done) begin
                    r_req    <= 1'b0;
                    r_cnt    <= '0;
                    r_last   <= r_owner;
                    r_rvalid <= ~w_cmp_err;
                    r_err    <= w_cmp_err;
                    r_rdata  <= (~vproc_mem_err_i & vproc_mem_rvalid_i) ? vproc_mem_rdata_i : '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_rdata <= '0;
            end
        end
    end

    assign i_gnt             = r_gnt & (r_owner == OWN_INSTR);
    assign d_gnt             = r_gnt & (r_owner == OWN_DATA);
    assign i_rvalid          = r_rvalid & (r_owner == OWN_INSTR);
    assign d_rvalid          = r_rvalid & (r_owner == OWN_DATA);
    assign i_err             = r_err & (r_owner == OWN_INSTR);
    assign d_err             = r_err & (r_owner == OWN_DATA);
    assign i_rdata           = (r_owner == OWN_INSTR) ? r_rdata : '0;
    assign d_rdata           = (r_owner == OWN_DATA) ? r_rdata : '0;
    assign vproc_mem_req_o   = r_req;
    assign vproc_mem_we_o    = r_we;
    assign vproc_mem_addr_o  = r_addr;
    assign vproc_mem_be_o    = r_be;
    assign vproc_mem_wdata_o = r_wdata;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed self-checking bench for the two-master MMU request arbiter.
module tb_mem_req_arbiter;
    localparam int MEM_W   = 32;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0;
    logic [3:0] d_be = '0;
    logic [31:0] d_wdata = '0;
    logic vproc_mem_rvalid_i = 1'b0, vproc_mem_err_i = 1'b0;
    logic [31:0] vproc_mem_rdata_i = '0;
    logic i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err;
    logic [31:0] i_rdata, d_rdata;
    logic vproc_mem_req_o, vproc_mem_we_o;
    logic [31:0] vproc_mem_addr_o, vproc_mem_wdata_o;
    logic [3:0] vproc_mem_be_o;
    int checks = 0;
    int failures = 0;

    wire [139:0] w_all = {i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, vproc_mem_req_o,
                          vproc_mem_we_o, i_rdata, d_rdata, vproc_mem_addr_o, vproc_mem_be_o,
                          vproc_mem_wdata_o};
    wire [4:0] w_rsp = {i_rvalid, i_err, d_rvalid, d_err, vproc_mem_req_o};

    mem_req_arbiter #(.MEM_W(MEM_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_err(i_err),
        .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
        .vproc_mem_req_o(vproc_mem_req_o), .vproc_mem_we_o(vproc_mem_we_o),
        .vproc_mem_addr_o(vproc_mem_addr_o), .vproc_mem_be_o(vproc_mem_be_o),
        .vproc_mem_wdata_o(vproc_mem_wdata_o), .vproc_mem_rvalid_i(vproc_mem_rvalid_i),
        .vproc_mem_err_i(vproc_mem_err_i), .vproc_mem_rdata_i(vproc_mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (w_all !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", w_all);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (w_all !== '0) begin
            failures++;
            $display("FAIL idle_after_reset got=%h exp=0", w_all);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp;
        i_addr = 32'h0000_1000;
        d_addr = 32'h0000_1800;
        i_req = 1'b1;
        d_req = 1'b1;
        vproc_mem_rvalid_i = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            exp = {c == 0 || c == 6, c == 3};
            checks++;
            if ({i_gnt, d_gnt} !== exp) begin
                failures++;
                $display("FAIL rr_grant c=%0d got=%b exp=%b", c, {i_gnt, d_gnt}, exp);
            end
            if (c == 3) begin
                checks++;
                if (vproc_mem_addr_o !== 32'h0000_1800) begin
                    failures++;
                    $display("FAIL rr_data_addr got=%h exp=00001800", vproc_mem_addr_o);
                end
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        vproc_mem_rvalid_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_read;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h0000_1004;
        d_be = 4'hf;
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt, vproc_mem_req_o, vproc_mem_we_o, vproc_mem_addr_o} !== {4'b0110, 32'h0000_1004}) begin
            failures++;
            $display("FAIL read_issue got=%b/%h exp=0110/00001004",
                     {i_gnt, d_gnt, vproc_mem_req_o, vproc_mem_we_o}, vproc_mem_addr_o);
        end
        d_req = 1'b0;
        d_addr = 32'h0000_0bad;
        @(negedge clk);
        checks++;
        if ({d_gnt, vproc_mem_req_o, d_rvalid, vproc_mem_addr_o} !== {3'b010, 32'h0000_1004}) begin
            failures++;
            $display("FAIL read_hold got=%b/%h exp=010/00001004",
                     {d_gnt, vproc_mem_req_o, d_rvalid}, vproc_mem_addr_o);
        end
        vproc_mem_rvalid_i = 1'b1;
        vproc_mem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({d_rvalid, d_err, i_rvalid, vproc_mem_req_o, d_rdata} !== {4'b1000, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL read_resp got=%b/%h exp=1000/deadbeef",
                     {d_rvalid, d_err, i_rvalid, vproc_mem_req_o}, d_rdata);
        end
        vproc_mem_rvalid_i = 1'b0;
        vproc_mem_rdata_i = '0;
        @(negedge clk);
        checks++;
        if ({d_rvalid, vproc_mem_req_o} !== 2'b00) begin
            failures++;
            $display("FAIL read_pulse_end got=%b exp=00", {d_rvalid, vproc_mem_req_o});
        end
    endtask

    task automatic test_timeout_write;
        int n = 0;
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 32'h0000_0115;
        d_wdata = 32'h5;
        d_be = 4'hf;
        @(negedge clk);
        checks++;
        if ({d_gnt, vproc_mem_we_o, vproc_mem_addr_o, vproc_mem_wdata_o} !== {2'b11, 32'h115, 32'h5}) begin
            failures++;
            $display("FAIL write_issue got=%b/%h/%h exp=11/00000115/00000005",
                     {d_gnt, vproc_mem_we_o}, vproc_mem_addr_o, vproc_mem_wdata_o);
        end
        d_req = 1'b0;
        d_we = 1'b0;
        d_wdata = '0;
        while (!d_rvalid && !d_err && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== TIMEOUT) begin
            failures++;
            $display("FAIL write_timeout_latency got=%0d exp=%0d", n, TIMEOUT);
        end
        checks++;
        if ({d_rvalid, d_err, vproc_mem_req_o, d_rdata} !== {3'b100, 32'h0}) begin
            failures++;
            $display("FAIL write_timeout_resp got=%b/%h exp=100/0",
                     {d_rvalid, d_err, vproc_mem_req_o}, d_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout_read;
        int n = 0;
        i_req = 1'b1;
        i_addr = 32'h0000_2000;
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt, vproc_mem_we_o, vproc_mem_be_o, vproc_mem_wdata_o} !== {3'b100, 4'hf, 32'h0}) begin
            failures++;
            $display("FAIL instr_issue got=%b/%h/%h exp=100/f/0",
                     {i_gnt, d_gnt, vproc_mem_we_o}, vproc_mem_be_o, vproc_mem_wdata_o);
        end
        i_req = 1'b0;
        while (!i_rvalid && !i_err && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== TIMEOUT) begin
            failures++;
            $display("FAIL read_timeout_latency got=%0d exp=%0d", n, TIMEOUT);
        end
        checks++;
        if ({i_err, i_rvalid, d_err, i_rdata} !== {3'b100, 32'h0}) begin
            failures++;
            $display("FAIL read_timeout_resp got=%b/%h exp=100/0", {i_err, i_rvalid, d_err}, i_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_err_priority;
        d_req = 1'b1;
        d_addr = 32'h0000_1008;
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);
        vproc_mem_err_i = 1'b1;
        vproc_mem_rvalid_i = 1'b1;
        vproc_mem_rdata_i = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if ({d_err, d_rvalid, vproc_mem_req_o, d_rdata} !== {3'b100, 32'h0}) begin
            failures++;
            $display("FAIL err_wins got=%b/%h exp=100/0", {d_err, d_rvalid, vproc_mem_req_o}, d_rdata);
        end
        vproc_mem_err_i = 1'b0;
        vproc_mem_rvalid_i = 1'b0;
        @(negedge clk);
        vproc_mem_rvalid_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vproc_mem_rvalid_i = 1'b0;
            checks++;
            if (w_rsp !== 5'b0) begin
                failures++;
                $display("FAIL spurious_rvalid c=%0d got=%b exp=00000", c, w_rsp);
            end
        end
    endtask

    task automatic test_reset_in_wait;
        d_req = 1'b1;
        d_addr = 32'h0000_1010;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rstwait_issue got=%b exp=1", d_gnt);
        end
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (w_all !== '0) begin
            failures++;
            $display("FAIL rstwait_async_clear got=%h exp=0", w_all);
        end
        @(negedge clk);
        vproc_mem_rvalid_i = 1'b1;
        @(negedge clk);
        vproc_mem_rvalid_i = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (w_rsp !== 5'b0) begin
                failures++;
                $display("FAIL rstwait_no_resp c=%0d got=%b exp=00000", c, w_rsp);
            end
        end
        i_req = 1'b1;
        d_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL rstwait_instr_priority got=%b exp=10", {i_gnt, d_gnt});
        end
        i_req = 1'b0;
        d_req = 1'b0;
        vproc_mem_rvalid_i = 1'b1;
        @(negedge clk);
        vproc_mem_rvalid_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_timeout_write();
        test_err_priority();
        test_timeout_read();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
